// File: rtl/fpu_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_arbiter
// Round-robin scheduler sharing one fpu among NREQ requesters. It accepts one
// request at a time, latches its operands, runs the fpu start/done handshake
// and returns the result to the owner. Invalid ops (op == 2'b11) bypass the fpu
// and return a quiet NaN.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req/req_a/req_b/req_op  packed per-requester request, operands and op
//   gnt                 one-hot accept pulse
//   rsp_valid, rsp_r    one-hot response pulse and result word
//   busy                arbiter is not idle
//   fpu_A/fpu_B/fpu_op/fpu_start  drive the fpu; fpu_R/fpu_done from the fpu
//   rsp_err             (FPU_ARB_TIMEOUT_EN only) response produced by timeout
//
// Optional feature: define FPU_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles without fpu_done.
// -----------------------------------------------------------------------------
module fpu_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [2*NREQ-1:0]    req_op,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_r,
    output logic                 busy,
    output logic [31:0]          fpu_A,
    output logic [31:0]          fpu_B,
    output logic [1:0]           fpu_op,
    output logic                 fpu_start,
    input  logic [31:0]          fpu_R,
    input  logic                 fpu_done
`ifdef FPU_ARB_TIMEOUT_EN
    ,
    output logic                 rsp_err
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [31:0]     QNAN    = 32'h7FC00000;
    localparam logic [NREQ-1:0] ONE_HOT = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // Pointer arithmetic is modulo NREQ, which need not be a power of two.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end else begin
            s = s;
        end
        return PW'(s);
    endfunction

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_r_q, rsp_r_d;
    logic [31:0]     fpu_a_q, fpu_a_d;
    logic [31:0]     fpu_b_q, fpu_b_d;
    logic [1:0]      fpu_op_q, fpu_op_d;
    logic            fpu_start_q, fpu_start_d;
    logic            first_q, first_d;
    logic            busy_q, busy_d;
    logic            sel_found_s;
    logic [PW-1:0]   sel_idx_s;
    logic [1:0]      sel_op_s;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_pend_q, err_pend_d;
    logic            rsp_err_q, rsp_err_d;
`endif

    // Rotating priority search: first set req bit at or after the pointer.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!sel_found_s && req[wrap_add(ptr_q, k)]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = wrap_add(ptr_q, k);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        sel_op_s = req_op[2*int'(sel_idx_s) +: 2];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_r_d     = rsp_r_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        fpu_op_d    = fpu_op_q;
        fpu_start_d = 1'b0;
        first_d     = first_q;
`ifdef FPU_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_pend_d  = err_pend_q;
        rsp_err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (sel_found_s) begin
                    owner_d  = sel_idx_s;
                    gnt_d    = ONE_HOT << sel_idx_s;
                    fpu_a_d  = req_a[32*int'(sel_idx_s) +: 32];
                    fpu_b_d  = req_b[32*int'(sel_idx_s) +: 32];
                    fpu_op_d = sel_op_s;
                    if (sel_op_s == 2'b11) begin
                        rsp_r_d = QNAN;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                fpu_start_d = 1'b1;
                first_d     = 1'b1;
                state_d     = S_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
                cnt_d       = '0;
                err_pend_d  = 1'b0;
`endif
            end
            S_WAIT: begin
                first_d = 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
                cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
`endif
                // done may still be high from the previous op during the
                // start cycle, so it is only trusted from the second cycle.
                if (!first_q && fpu_done) begin
                    rsp_r_d = fpu_R;
                    state_d = S_RESP;
`ifdef FPU_ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    rsp_r_d    = QNAN;
                    err_pend_d = 1'b1;
                    state_d    = S_RESP;
`endif
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                rsp_valid_d = ONE_HOT << owner_q;
                ptr_d       = wrap_add(owner_q, 1);
                state_d     = S_IDLE;
`ifdef FPU_ARB_TIMEOUT_EN
                rsp_err_d   = err_pend_q;
                err_pend_d  = 1'b0;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_r_q     <= 32'h0000_0000;
            fpu_a_q     <= 32'h0000_0000;
            fpu_b_q     <= 32'h0000_0000;
            fpu_op_q    <= 2'b00;
            fpu_start_q <= 1'b0;
            first_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_pend_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r_q     <= rsp_r_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_op_q    <= fpu_op_d;
            fpu_start_q <= fpu_start_d;
            first_q     <= first_d;
            busy_q      <= busy_d;
`ifdef FPU_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_pend_q  <= err_pend_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_r     = rsp_r_q;
    assign busy      = busy_q;
    assign fpu_A     = fpu_a_q;
    assign fpu_B     = fpu_b_q;
    assign fpu_op    = fpu_op_q;
    assign fpu_start = fpu_start_q;
`ifdef FPU_ARB_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`endif

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Round-robin scheduler that shares one fpu instance among NREQ requesters.
- Owns the fpu handshake: presents operands, pulses fpu_start, waits for fpu_done, captures fpu_R and returns the result to the granted requester.
- Sits between the requesting units and the fpu. It is the only driver of the fpu A/B/op/start inputs.

Parameters:
- NREQ, 4: number of requesters (2..8).
- TIMEOUT, 255: maximum WAIT cycles before abort (used only with FPU_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  request vector; bit i held high by requester i until gnt[i].
- req_a  in  32*NREQ  operand A of requester i at bits [32*i+31:32*i].
- req_b  in  32*NREQ  operand B of requester i, same packing as req_a.
- req_op  in  2*NREQ  op of requester i at [2*i+1:2*i]; 00 add, 01 sub, 10 mult, 11 invalid.
- gnt  out  NREQ  one-hot, 1-cycle pulse when a request is accepted.
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse; rsp_r is valid for that requester.
- rsp_r  out  32  result word, held until the next rsp_valid.
- busy  out  1  high whenever the state is not IDLE.
- fpu_A  out  32  operand A to the fpu.
- fpu_B  out  32  operand B to the fpu.
- fpu_op  out  2  op to the fpu.
- fpu_start  out  1  start pulse to the fpu.
- fpu_R  in  32  fpu result.
- fpu_done  in  1  fpu done level.

Behaviour:
- Reset (rst=0, asynchronous) clears the following:
  - state=IDLE, round-robin pointer=0, owner=0.
  - gnt, rsp_valid, busy, fpu_start=0.
  - rsp_r, fpu_A, fpu_B, fpu_op=0.
  - Any in-flight operation is abandoned with no response.
- IDLE:
  - If req!=0, select the first set bit searching upward from pointer with wrap-around (pointer, pointer+1, ..., NREQ-1, 0, ...).
  - Latch that requester's A, B and op into fpu_A/fpu_B/fpu_op and set owner=i. Pulse gnt[i] on the same edge.
  - If op!=11, go to ISSUE. If op==11, go to RESP with result 32'h7FC00000 (qNaN) and the fpu untouched.
  - If req==0, stay in IDLE.
- ISSUE: fpu_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - fpu_done is ignored in the first WAIT cycle, because the fpu clears done asynchronously on start.
  - From the second WAIT cycle on, fpu_done=1 captures fpu_R into rsp_r and moves to RESP.
- RESP:
  - rsp_valid[owner]=1 for one cycle.
  - pointer=owner+1, wrapping NREQ-1 to 0. Go to IDLE.
- Operand holding:
  - fpu_A/fpu_B/fpu_op stay stable from IDLE exit until RESP exit.
  - Requester inputs may change freely after gnt.
- Latency:
  - gnt to rsp_valid = 3 + L cycles, where L = number of fpu cycles from start to done (L>=1).
  - Invalid op: gnt to rsp_valid = 1 cycle.
- Throughput: one request in flight at most. Back-to-back requests from different requesters are separated by one IDLE cycle.
- Request handling:
  - A requester still asserting req after its gnt is treated as a new request, subject to rotation.
  - A req bit dropped before gnt is withdrawn; no response is produced.
- Simultaneous events:
  - A request arriving during RESP is considered in the following IDLE cycle.
  - All requesters asserting at once are served in pointer order. No requester waits longer than NREQ-1 other operations.
- Pointer width is ceil(log2(NREQ)). The arithmetic is modulo NREQ, not modulo a power of two.

Optional Feature:
- Macro: FPU_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider WAIT cycle counter runs, cleared on entry to WAIT.
  - When the counter reaches TIMEOUT with no fpu_done, go to RESP with rsp_r=32'h7FC00000.
  - The extra port rsp_err (out, 1) pulses with rsp_valid on a timeout response and is 0 otherwise.
  - Pointer advances as usual.
- Undefined: no counter and no rsp_err port. WAIT blocks indefinitely until fpu_done.

Test Plan:
- Single add, using an fpu stub with L=4:
  - Stimulus: req[1]=1, A=32'h3F800000, B=32'h40000000, op=00.
  - Required: gnt[1] one cycle later; fpu_start exactly 1 cycle; rsp_valid[1] 7 cycles after gnt; rsp_r=32'h40400000.
- Mult: A=32'h40000000, B=32'h40400000, op=10 on requester 0 → rsp_r=32'h40C00000, rsp_valid[0] only.
- Fairness, all four requesters held high for 8 operations:
  - Grant order is 0,1,2,3,0,1,2,3.
  - Exactly one fpu_start per grant.
  - Exactly one IDLE cycle between each rsp_valid and the next gnt.
- Stale done:
  - Stimulus: fpu_done held at 1 from the previous op when start is issued; stub drops done one cycle later and raises it at L=3.
  - Required: rsp_r is the new result, not the old one.
- Invalid op and reset:
  - req[2] with op=11 → rsp_valid[2] 1 cycle after gnt, rsp_r=32'h7FC00000, no fpu_start.
  - rst=0 pulsed mid-WAIT → all outputs 0 immediately; no rsp_valid afterward; next grant goes to requester 0.
- Timeout (FPU_ARB_TIMEOUT_EN defined, TIMEOUT=16):
  - Stimulus: stub never asserts done.
  - Required: rsp_valid and rsp_err 16 WAIT cycles after entering WAIT; rsp_r=32'h7FC00000; next grant proceeds normally.
